// File: rtl/banco_reg_if.sv
// Register-file access bus: one write port and two independent read ports.
// The master drives indices, write enable and write data; the slave returns read data.
interface banco_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output RegWrite,
        output WriteReg,
        output WriteData,
        output ReadReg1,
        output ReadReg2,
        input  ReadData1,
        input  ReadData2
    );

    modport slave (
        input  RegWrite,
        input  WriteReg,
        input  WriteData,
        input  ReadReg1,
        input  ReadReg2,
        output ReadData1,
        output ReadData2
    );
endinterface

// File: rtl/banco_reg.sv
// banco_reg: 2**ADDR_W x DATA_W register file.
// Register 0 is hard-wired to zero. Reads are combinational with a same-cycle
// write-to-read bypass. Reset is synchronous, active-high, and clears every register.
module banco_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    banco_reg_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // A write is live only outside reset and never targets register 0; the same
    // qualifier gates the bypass so that reset reads show stored contents.
    logic wr_en;
    assign wr_en = bus.RegWrite && !rst && (bus.WriteReg != '0);

    // Register storage: synchronous clear on reset, otherwise single-entry write.
    // NOTE: the array is cleared here because readers must see 0 everywhere after
    // reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: sequential state uses <= so every register samples pre-edge values.
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    // Read ports: index 0 forces zero, a matching live write bypasses storage.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        bus.ReadData1 = regs[bus.ReadReg1];
        bus.ReadData2 = regs[bus.ReadReg2];

        if (bus.ReadReg1 == '0) begin
            bus.ReadData1 = '0;
        end else if (wr_en && (bus.WriteReg == bus.ReadReg1)) begin
            bus.ReadData1 = bus.WriteData;
        end

        if (bus.ReadReg2 == '0) begin
            bus.ReadData2 = '0;
        end else if (wr_en && (bus.WriteReg == bus.ReadReg2)) begin
            bus.ReadData2 = bus.WriteData;
        end
    end
endmodule

// File: tb/tb_banco_reg.sv
// Directed testbench for banco_reg: each task drives one scenario and checks
// the read ports against hand-computed values.
module tb_banco_reg;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    banco_reg_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    banco_reg #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commit one write on the next edge, then drop the enable.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = addr;
        bus.WriteData = data;
        tick();
        bus.RegWrite  = 1'b0;
    endtask

    // One reset edge.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Point both ports at the given indices and let the combinational path settle.
    task automatic read_both(input logic [4:0] a1, input logic [4:0] a2);
        bus.ReadReg1 = a1;
        bus.ReadReg2 = a2;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            read_both(5'(i), 5'(31 - i));
            n_checks++;
            if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_clear idx=%0d: got p1=%h p2=%h, want 0", i, bus.ReadData1, bus.ReadData2);
            end
        end
    endtask

    task automatic test_basic_write();
        do_write(5'd5, 32'hDEADBEEF);
        read_both(5'd5, 5'd6);
        n_checks++;
        if (bus.ReadData1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_write: got %h, want deadbeef", bus.ReadData1);
        end
        n_checks++;
        if (bus.ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_neighbour6: got %h, want 0", bus.ReadData2);
        end
        read_both(5'd4, 5'd21);
        n_checks++;
        if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_neighbours: got p1=%h p2=%h, want 0", bus.ReadData1, bus.ReadData2);
        end
    endtask

    task automatic test_reg_zero();
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd0;
        bus.WriteData = 32'hFFFFFFFF;
        read_both(5'd0, 5'd0);
        n_checks++;
        if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reg0_same_cycle: got p1=%h p2=%h, want 0", bus.ReadData1, bus.ReadData2);
        end
        tick();
        bus.RegWrite = 1'b0;
        #1;
        n_checks++;
        if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reg0_after_edge: got p1=%h p2=%h, want 0", bus.ReadData1, bus.ReadData2);
        end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h11111111);
        read_both(5'd7, 5'd7);
        n_checks++;
        if (bus.ReadData2 !== 32'h11111111) begin
            n_fail++;
            $display("FAIL bypass_prior: got %h, want 11111111", bus.ReadData2);
        end
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd7;
        bus.WriteData = 32'h22222222;
        #1;
        n_checks++;
        if (bus.ReadData2 !== 32'h22222222 || bus.ReadData1 !== 32'h22222222) begin
            n_fail++;
            $display("FAIL bypass_before_edge: got p1=%h p2=%h, want 22222222", bus.ReadData1, bus.ReadData2);
        end
        tick();
        bus.RegWrite  = 1'b0;
        bus.WriteData = 32'h33333333;
        #1;
        n_checks++;
        if (bus.ReadData2 !== 32'h22222222) begin
            n_fail++;
            $display("FAIL bypass_after_edge: got %h, want 22222222", bus.ReadData2);
        end
    endtask

    task automatic test_reset_priority();
        do_write(5'd3, 32'h0000ABCD);
        read_both(5'd3, 5'd3);
        rst           = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd3;
        bus.WriteData = 32'h12345678;
        #1;
        n_checks++;
        if (bus.ReadData1 !== 32'h0000ABCD) begin
            n_fail++;
            $display("FAIL reset_no_bypass: got %h, want 0000abcd", bus.ReadData1);
        end
        tick();
        rst          = 1'b0;
        bus.RegWrite = 1'b0;
        #1;
        n_checks++;
        if (bus.ReadData1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_priority: got %h, want 0", bus.ReadData1);
        end
    endtask

    task automatic test_boundary();
        do_write(5'd31, 32'hA5A5A5A5);
        do_write(5'd1,  32'h5A5A5A5A);
        read_both(5'd31, 5'd1);
        n_checks++;
        if (bus.ReadData1 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL boundary_p1_r31: got %h, want a5a5a5a5", bus.ReadData1);
        end
        n_checks++;
        if (bus.ReadData2 !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("FAIL boundary_p2_r1: got %h, want 5a5a5a5a", bus.ReadData2);
        end
    endtask

    task automatic test_held_write();
        do_write(5'd4, 32'h44444444);
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = 5'd4;
        bus.WriteData = 32'hCAFEF00D;
        read_both(5'd4, 5'd4);
        n_checks++;
        if (bus.ReadData1 !== 32'h44444444) begin
            n_fail++;
            $display("FAIL held_no_bypass: got %h, want 44444444", bus.ReadData1);
        end
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (bus.ReadData1 !== 32'h44444444 || bus.ReadData2 !== 32'h44444444) begin
            n_fail++;
            $display("FAIL held_write: got p1=%h p2=%h, want 44444444", bus.ReadData1, bus.ReadData2);
        end
        bus.WriteData = 'x;
        tick();
        n_checks++;
        if (bus.ReadData1 !== 32'h44444444) begin
            n_fail++;
            $display("FAIL held_x_data: got %h, want 44444444", bus.ReadData1);
        end
    endtask

    task automatic test_back_to_back();
        bus.RegWrite = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            bus.WriteReg  = 5'(i);
            bus.WriteData = 32'h1000_0000 + 32'(i);
            tick();
        end
        bus.RegWrite = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            read_both(5'(i), 5'(25 - i));
            n_checks++;
            if (bus.ReadData1 !== 32'h1000_0000 + 32'(i) || bus.ReadData2 !== 32'h1000_0000 + 32'(25 - i)) begin
                n_fail++;
                $display("FAIL back_to_back idx=%0d: got p1=%h p2=%h, want %h %h", i, bus.ReadData1,
                         bus.ReadData2, 32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(25 - i));
            end
        end
    endtask

    task automatic test_reset_between_writes();
        do_write(5'd9, 32'h99999999);
        do_reset();
        do_write(5'd10, 32'hAAAA5555);
        read_both(5'd9, 5'd10);
        n_checks++;
        if (bus.ReadData1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_between_r9: got %h, want 0", bus.ReadData1);
        end
        n_checks++;
        if (bus.ReadData2 !== 32'hAAAA5555) begin
            n_fail++;
            $display("FAIL reset_between_r10: got %h, want aaaa5555", bus.ReadData2);
        end
        read_both(5'd5, 5'd31);
        n_checks++;
        if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_between_old: got p1=%h p2=%h, want 0", bus.ReadData1, bus.ReadData2);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = '0;
        bus.WriteData = '0;
        bus.ReadReg1  = '0;
        bus.ReadReg2  = '0;

        test_reset();
        test_basic_write();
        test_reg_zero();
        test_bypass();
        test_reset_priority();
        test_boundary();
        test_held_write();
        test_back_to_back();
        test_reset_between_writes();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
